// File: rtl/uart_tx_ctrl_pkg.sv
// Shared frame-phase encodings for the UART TX controller and the TX line mux.
// The state value doubles as the mux select, so both sides decode the same codes.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b011,
    ST_PARITY = 3'b010,
    ST_STOP   = 3'b110
  } state_t;

  localparam int MUX_SEL_W = 5;

  function automatic logic [MUX_SEL_W-1:0] mux_sel_of(input state_t s);
    return {2'b00, s};
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_serializer.sv
// LSB-first shift register with bit counter; loads in one cycle, shifts one bit per enabled cycle.
// No backpressure: the controlling FSM owns when load/shift/clear happen.
module uart_tx_ctrl_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_clr,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit,
  output logic                  o_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      if (i_load)
        r_shift <= i_data;
      else if (i_shift)
        r_shift <= r_shift >> 1;

      if (i_clr)
        r_cnt <= '0;
      else if (i_shift)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_bit  = r_shift[0];
  // Asserted during the last data bit so the FSM leaves DATA on that edge.
  assign o_done = (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame FSM and parity generator; drives the TX mux select, data bit and parity bit.
// Frame = DATA_WIDTH+2 (+1 with parity) cycles after the accepting edge; inputs ignored while busy.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [MUX_SEL_W-1:0]  mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  state_t r_state;
  logic   r_busy;
  logic   r_par_bit;
  logic   r_par_en;
  logic   w_load;
  logic   w_clr;
  logic   w_shift;
  logic   w_bit;
  logic   w_done;

  assign w_load  = (r_state == ST_IDLE) && data_valid;
  assign w_clr   = (r_state == ST_START);
  assign w_shift = (r_state == ST_DATA);

  uart_tx_ctrl_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_data  (p_data),
    .o_bit   (w_bit),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (data_valid) begin
            r_state   <= ST_START;
            r_busy    <= 1'b1;
            r_par_bit <= (^p_data) ^ par_typ;
            r_par_en  <= par_en;
          end
        end
        ST_START: r_state <= ST_DATA;
        ST_DATA: begin
          if (w_done)
            r_state <= r_par_en ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: r_state <= ST_STOP;
        ST_STOP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mux_sel  = mux_sel_of(r_state);
  assign ser_data = w_bit;
  assign par_bit  = r_par_bit;
  assign busy     = r_busy;

endmodule
